// File: rtl/ffsr_pulse.sv
// Unary up/down counter held in thermometer form in a feed-forward shift register.
// rst loads init level-sensitively through per-bit asynchronous set/clear flops.
module ffsr_pulse #(
  parameter int INPUT_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  dec,
  input  logic [0:INPUT_SIZE-1] init,
  output logic [0:INPUT_SIZE-1] out
);

  logic [0:INPUT_SIZE-1] next_s;
  logic [0:INPUT_SIZE-1] set_s;
  logic [0:INPUT_SIZE-1] clr_s;

  // Asynchronous load decoded per bit, so out tracks init for as long as rst is high.
  assign set_s = {INPUT_SIZE{rst}} & init;
  assign clr_s = {INPUT_SIZE{rst}} & ~init;

  // Next-state shift: inc pushes a 1 in at out[0], dec pushes a 0 in at the far end.
  always_comb begin
    next_s = out;
    case ({inc, dec})
      2'b10:   next_s = {1'b1, out[0:INPUT_SIZE-2]};
      2'b01:   next_s = {out[1:INPUT_SIZE-1], 1'b0};
      default: next_s = out;
    endcase
  end

  for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_bit
    logic q_r;

    // State bit with asynchronous clear/set from the load decode.
    always_ff @(posedge clk or posedge set_s[i] or posedge clr_s[i]) begin
      if (clr_s[i]) begin
        q_r <= 1'b0;
      end else if (set_s[i]) begin
        q_r <= 1'b1;
      end else begin
        q_r <= next_s[i];
      end
    end

    assign out[i] = q_r;
  end

endmodule

// File: tb/tb_ffsr_pulse.sv
// Directed self-checking bench for ffsr_pulse (INPUT_SIZE = 16).
module tb_ffsr_pulse;

  localparam int N = 16;

  logic         clk;
  logic         rst;
  logic         inc;
  logic         dec;
  logic [0:N-1] init;
  logic [0:N-1] out;

  int errors;
  int checks;

  typedef struct {
    logic         inc;
    logic         dec;
    logic [0:N-1] exp;
  } vec_t;

  vec_t vecs[$];

  ffsr_pulse #(.INPUT_SIZE(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc),
    .dec  (dec),
    .init (init),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:N-1] therm(input int k);
    logic [0:N-1] ones;
    ones = 16'hFFFF;
    return ~(ones >> k);
  endfunction

  task automatic check(input string name, input logic [0:N-1] exp);
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL %s: out=%h expected=%h", name, out, exp);
    end
  endtask

  task automatic add(input logic i, input logic d, input logic [0:N-1] e);
    vec_t v;
    v.inc = i;
    v.dec = d;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic step(input logic i, input logic d);
    @(negedge clk);
    inc = i;
    dec = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst  = 1'b0;
    inc  = 1'b0;
    dec  = 1'b0;
    init = 16'h0000;

    // Vector table: count up, saturate, count down, saturate, then inc=dec / idle holds.
    add(1'b1, 1'b0, 16'h8000);
    add(1'b1, 1'b0, 16'hC000);
    add(1'b1, 1'b0, 16'hE000);
    for (int k = 4; k <= 16; k++) add(1'b1, 1'b0, therm(k));
    add(1'b1, 1'b0, 16'hFFFF);
    for (int k = 15; k >= 0; k--) add(1'b0, 1'b1, therm(k));
    add(1'b0, 1'b1, 16'h0000);
    add(1'b1, 1'b0, 16'h8000);
    add(1'b1, 1'b0, 16'hC000);
    add(1'b1, 1'b1, 16'hC000);
    add(1'b1, 1'b1, 16'hC000);
    add(1'b0, 1'b0, 16'hC000);
    add(1'b0, 1'b0, 16'hC000);

    // Reset load: out follows init with no clock edge in between.
    #2;
    init = 16'hAAAA;
    rst  = 1'b1;
    #1 check("rst_async_load", 16'hAAAA);
    init = 16'h0000;
    #1 check("rst_init_zero", 16'h0000);
    @(negedge clk);
    init = 16'hE000;
    #1 check("rst_init_follow", 16'hE000);
    inc = 1'b1;
    @(posedge clk);
    #1 check("rst_ignores_inc", 16'hE000);
    @(negedge clk);
    inc  = 1'b0;
    init = 16'h0000;
    #1 check("rst_init_back0", 16'h0000);
    rst = 1'b0;
    #1 check("rst_release_hold", 16'h0000);

    foreach (vecs[i]) begin
      step(vecs[i].inc, vecs[i].dec);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Async reset mid-count, then counting resumes from init.
    step(1'b1, 1'b0);
    check("pre_rst_count", 16'hE000);
    init = 16'h8000;
    #2 rst = 1'b1;
    #1 check("mid_rst_immediate", 16'h8000);
    rst = 1'b0;
    #1 check("mid_rst_release", 16'h8000);
    @(posedge clk);
    #1 check("resume1", 16'hC000);
    @(posedge clk);
    #1 check("resume2", 16'hE000);

    // Non-thermometer init shifted mechanically.
    @(negedge clk);
    inc  = 1'b0;
    init = 16'h5000;
    rst  = 1'b1;
    #1 check("nt_load", 16'h5000);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0);
    check("nt_inc", 16'hA800);
    @(negedge clk);
    inc = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1);
    check("nt_dec", 16'hA000);
    step(1'b0, 1'b0);
    check("nt_hold", 16'hA000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
